// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one read per cycle into a
// one-cycle synchronous memory, and buffers returned words for decode.
//
// Operating phases are implicit in count/inflight/run:
//   phase         | meaning
//   IDLE          | run = 0 and nothing in flight or buffered
//   FILL          | reads issued, buffer not yet presenting a word
//   STREAM        | one word per cycle with out_ready = 1
//   BACKPRESSURED | buffer full (count = 2), no new issue
module instr_fetch_ctrl #(
  parameter int                 ADDR_W   = 15,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [ADDR_W-1:0] buf_pc    [2];
  logic [DATA_W-1:0] buf_instr [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ_after_pop;

  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = buf_pc[rd_ptr];
  assign out_instr = buf_instr[rd_ptr];

  assign pop  = out_valid && out_ready;
  assign push = inflight && !redirect_valid;

  // Reserve a slot for every outstanding read so the buffer cannot overflow.
  assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = run && (redirect_valid || (occ_after_pop < 3'd2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= imem_addr;
        fetch_pc    <= imem_addr + 1'b1;
      end else begin
        inflight <= 1'b0;
        if (redirect_valid) begin
          fetch_pc <= redirect_pc;
        end
      end

      // A redirect drops the returning word and all buffered entries; a
      // coincident pop has already been taken by decode.
      if (redirect_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]    <= inflight_pc;
          buf_instr[wr_ptr] <= imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: memory word k = 0x1000_0000 + k, every accepted
// instruction is checked against a queue of expected PCs.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  instr_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle synchronous read memory.
  logic [ADDR_W-1:0] addr_q;
  always @(posedge clk) addr_q <= imem_addr;
  assign imem_rdata = 32'h1000_0000 + {17'b0, addr_q};

  typedef struct {
    logic [ADDR_W-1:0] target;
    int                nwords;
    logic [DATA_W-1:0] first_instr;
  } redir_rec_t;

  redir_rec_t        tbl [4];
  logic [ADDR_W-1:0] exp_q [$];
  int                errors;
  int                checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 1'b1;
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    run            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    tbl[0] = '{target: 15'h0100, nwords: 4, first_instr: 32'h1000_0100};
    tbl[1] = '{target: 15'h7FFE, nwords: 4, first_instr: 32'h1000_7FFE};
    tbl[2] = '{target: 15'h0040, nwords: 3, first_instr: 32'h1000_0040};
    tbl[3] = '{target: 15'h1234, nwords: 3, first_instr: 32'h1000_1234};

    // Scoreboard: every accepted word must match the head of exp_q.
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc 0x%0h expected none at %0t", out_pc, $time);
          end else begin
            logic [ADDR_W-1:0] p;
            p = exp_q.pop_front();
            check("pop_pc", {17'b0, out_pc}, {17'b0, p});
            check("pop_instr", out_instr, 32'h1000_0000 + {17'b0, p});
          end
        end
      end
    join_none

    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc", {17'b0, out_pc}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_imem_addr", {17'b0, imem_addr}, 32'd0);

    // Streaming from reset, then backpressure while pc 3 is at the head.
    step(2);
    push_seq(15'd0, 8);
    rst_n     = 1'b1;
    run       = 1'b1;
    out_ready = 1'b1;
    step(1);
    check("first_edge_valid", {31'b0, out_valid}, 32'd0);
    check("first_edge_addr", {17'b0, imem_addr}, 32'd1);
    step(1);
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", {17'b0, out_pc}, 32'd0);
    check("first_instr", out_instr, 32'h1000_0000);
    step(3);
    check("bp_head_pc", {17'b0, out_pc}, 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_pc", {17'b0, out_pc}, 32'd3);
      check("bp_hold_instr", out_instr, 32'h1000_0003);
    end
    check("bp_issue_stopped", {17'b0, imem_addr}, 32'd5);
    out_ready = 1'b1;
    step(4);

    // Table of redirects; the first lands on the same edge that pops pc 7.
    for (int r = 0; r < 4; r++) begin
      push_seq(tbl[r].target, tbl[r].nwords);
      redirect_valid = 1'b1;
      redirect_pc    = tbl[r].target;
      step(1);
      redirect_valid = 1'b0;
      check("redir_flush_valid", {31'b0, out_valid}, 32'd0);
      step(1);
      check("redir_valid", {31'b0, out_valid}, 32'd1);
      check("redir_pc", {17'b0, out_pc}, {17'b0, tbl[r].target});
      check("redir_instr", out_instr, tbl[r].first_instr);
      step(tbl[r].nwords - 1);
    end

    // Restart at 0, drop run after pc 4 is issued, then resume.
    push_seq(15'd0, 5);
    redirect_valid = 1'b1;
    redirect_pc    = 15'd0;
    step(1);
    redirect_valid = 1'b0;
    step(4);
    run = 1'b0;
    step(2);
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_addr", {17'b0, imem_addr}, 32'd5);
    step(3);
    check("idle_valid", {31'b0, out_valid}, 32'd0);
    push_seq(15'd5, 1);
    run = 1'b1;
    step(2);
    check("resume_valid", {31'b0, out_valid}, 32'd1);
    check("resume_pc", {17'b0, out_pc}, 32'd5);

    // Fill the buffer, then reset asynchronously mid-cycle.
    step(1);
    out_ready = 1'b0;
    step(3);
    check("full_pc", {17'b0, out_pc}, 32'd6);
    check("full_addr", {17'b0, imem_addr}, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_pc", {17'b0, out_pc}, 32'd0);
    check("async_rst_addr", {17'b0, imem_addr}, 32'd0);
    check("q_empty_before_rst", exp_q.size(), 32'd0);
    step(1);
    push_seq(15'd0, 2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step(2);
    check("rst_restart_valid", {31'b0, out_valid}, 32'd1);
    check("rst_restart_pc", {17'b0, out_pc}, 32'd0);
    step(2);
    out_ready = 1'b0;
    run       = 1'b0;
    step(3);
    check("q_empty_end", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
